// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning logic.
package button_pkg;

    // Debounce FSM states. The encoding values are fixed.
    typedef enum logic [1:0] {
        StReleased       = 2'd0,
        StConfirmPress   = 2'd1,
        StPressed        = 2'd2,
        StConfirmRelease = 2'd3
    } btn_state_e;

    // Default cycle counts for the 16 MHz board clock.
    localparam int unsigned DEBOUNCE_10MS = 32'd160000;
    localparam int unsigned LONG_1S       = 32'd16000000;

endpackage

// File: rtl/button_debouncer_if.sv
// Button signal bundle: raw pin in, conditioned level and strobes out.
interface button_debouncer_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    // Board side: drives the pin, consumes the conditioned outputs.
    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    // Debouncer side.
    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for any asynchronous board pin.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Shift the pin through two flops to settle metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchroniser, counter-based debounce FSM,
// registered level and one-cycle press/release strobes.
// Optional long-press strobe enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
    parameter bit          ACTIVE_LOW        = 1'b0,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_1S
) (
    input  logic               CLK,
    input  logic               RESET_N,
    button_debouncer_if.slave  btn_if
);
    localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic s_in;
    logic s;

    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // Normalise polarity before synchronising so reset value 0 means "not pressed".
    assign s_in = btn_if.btn_raw ^ ACTIVE_LOW;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .d_i    (s_in),
        .q_o    (s)
    );

    // State, confirm counter and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StReleased;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next state: a change is accepted after DEBOUNCE_CYCLES+1 agreeing samples;
    // any disagreeing sample drops back and the count restarts on the next change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StReleased: begin
                if (s) begin
                    state_d = StConfirmPress;
                    cnt_d   = CntW'(1);
                end
            end
            StConfirmPress: begin
                if (!s) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!s) begin
                    state_d = StConfirmRelease;
                    cnt_d   = CntW'(1);
                end
            end
            StConfirmRelease: begin
                if (s) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs: level and strobes change only on an accepted confirmation.
    always_comb begin
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (state_q == StConfirmPress && state_d == StPressed) begin
            level_d = 1'b1;
            press_d = 1'b1;
        end
        if (state_q == StConfirmRelease && state_d == StReleased) begin
            level_d   = 1'b0;
            release_d = 1'b1;
        end
    end

    assign btn_if.btn_level     = level_q;
    assign btn_if.press_pulse   = press_q;
    assign btn_if.release_pulse = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned     HoldW   = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_PRESS_CYCLES);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    // Hold counter: restarts on an accepted press, keeps running through a
    // rejected release glitch, saturates so the strobe fires once per hold.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d || release_d) begin
            hold_d = '0;
        end else if ((state_q == StPressed || state_q == StConfirmRelease) &&
                     hold_q != HoldMax) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HoldMax - 1'b1);
        end
    end

    // Hold counter and long-press strobe registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_if.long_press = long_q;
`else
    logic unused_long_cycles;
    assign unused_long_cycles = ^LONG_PRESS_CYCLES;
    assign btn_if.long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised bench for button_debouncer: two instances (active-high and
// active-low pin) compared each cycle against a run-length reference model.
module tb_button_debouncer;
    localparam int Deb  = 4;
    localparam int Long = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_debouncer_if bif0 ();
    button_debouncer_if bif1 ();

    button_debouncer #(
        .DEBOUNCE_CYCLES   (Deb),
        .ACTIVE_LOW        (1'b0),
        .LONG_PRESS_CYCLES (Long)
    ) u_dut_hi (
        .CLK     (clk),
        .RESET_N (rst_n),
        .btn_if  (bif0)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES   (Deb),
        .ACTIVE_LOW        (1'b1),
        .LONG_PRESS_CYCLES (Long)
    ) u_dut_lo (
        .CLK     (clk),
        .RESET_N (rst_n),
        .btn_if  (bif1)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: delayed sample queue, disagreement run length, hold time.
    logic m_pipe[$];
    int   m_streak;
    int   m_hold;
    logic m_level, m_press, m_rel, m_long;

    // Event bookkeeping on the active-high instance.
    int cyc = 0;
    int press_cyc = 0;
    int long_cnt = 0;
    int long_dist = -1;
    int rel_cnt = 0;
    int press_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        m_pipe.push_back(1'b0);
        m_pipe.push_back(1'b0);
        m_streak = 0;
        m_hold   = 0;
        m_level  = 1'b0;
        m_press  = 1'b0;
        m_rel    = 1'b0;
        m_long   = 1'b0;
    endtask

    // One clock edge: the FSM sees the pin as it was two edges ago; a new level
    // is accepted once Deb+1 consecutive seen samples disagree with the current one.
    task automatic model_edge(input logic raw);
        logic s;
        s = m_pipe.pop_front();
        m_pipe.push_back(raw);
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (s != m_level) m_streak++;
        else m_streak = 0;
        if (m_streak == Deb + 1) begin
            m_level  = s;
            m_streak = 0;
            m_press  = s;
            m_rel    = !s;
            m_hold   = 0;
        end else if (m_level && m_hold < Long) begin
            m_hold++;
            m_long = (m_hold == Long);
        end
    endtask

    task automatic check_all();
        logic exp_long;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        exp_long = m_long;
`else
        exp_long = 1'b0;
`endif
        check_eq("hi_level",   bif0.btn_level,     m_level);
        check_eq("hi_press",   bif0.press_pulse,   m_press);
        check_eq("hi_release", bif0.release_pulse, m_rel);
        check_eq("hi_long",    bif0.long_press,    exp_long);
        check_eq("lo_level",   bif1.btn_level,     m_level);
        check_eq("lo_press",   bif1.press_pulse,   m_press);
        check_eq("lo_release", bif1.release_pulse, m_rel);
        check_eq("lo_long",    bif1.long_press,    exp_long);
    endtask

    // Called at a negedge: drive the pin, take one edge, check at the next negedge.
    task automatic cycle(input logic raw);
        bif0.btn_raw = raw;
        bif1.btn_raw = ~raw;
        @(posedge clk);
        model_edge(raw);
        @(negedge clk);
        check_all();
        cyc++;
        if (bif0.press_pulse) begin
            press_cyc = cyc;
            press_cnt++;
        end
        if (bif0.release_pulse) rel_cnt++;
        if (bif0.long_press) begin
            long_cnt++;
            long_dist = cyc - press_cyc;
        end
    endtask

    // Called at a negedge: outputs must clear as soon as reset asserts.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int len;
        logic lvl;
        bif0.btn_raw = 1'b0;
        bif1.btn_raw = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset(3);

        // Idle after reset.
        repeat (50) cycle(1'b0);
        check_eq("idle_pulses", press_cnt + rel_cnt, 0);

        // Clean press: edge k is the k-th sampling edge of the held pin.
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1);
            check_eq("lat_level", bif0.btn_level, k >= 6);
            check_eq("lat_press", bif0.press_pulse, k == 6);
        end
        // Keep holding (48 edges total) to see the long-press strobe.
        long_cnt = 0;
        repeat (40) cycle(1'b1);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        check_eq("long_count", long_cnt, 1);
        check_eq("long_dist", long_dist, Long);
`else
        check_eq("long_count", long_cnt, 0);
`endif

        // Two-cycle glitch while pressed is rejected.
        rel_cnt = 0;
        cycle(1'b0);
        cycle(1'b0);
        repeat (10) cycle(1'b1);
        check_eq("glitch_release", rel_cnt, 0);
        check_eq("glitch_level", bif0.btn_level, 1);

        // Clean release.
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0);
            check_eq("rel_level", bif0.btn_level, k < 6);
            check_eq("rel_pulse", bif0.release_pulse, k == 6);
        end
        repeat (5) cycle(1'b0);

        // Bouncy press then a steady hold.
        press_cnt = 0;
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        check_eq("bounce_no_press", press_cnt, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1);
            check_eq("bounce_press", bif0.press_pulse, k == 6);
        end
        check_eq("bounce_press_count", press_cnt, 1);
        repeat (10) cycle(1'b0);

        // Reset with the confirm counter at 3, then a full confirmation is needed.
        repeat (5) cycle(1'b1);
        do_reset(2);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1);
            check_eq("post_rst_level", bif0.btn_level, k >= 6);
        end
        // Reset while pressed: level drops without a release strobe.
        do_reset(2);
        check_eq("rst_level_drop", bif0.btn_level, 0);

        // Random segments of held levels, mostly short, sometimes long, rare resets.
        for (int i = 0; i < 300; i++) begin
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, 40));
            else len = int'($urandom_range(1, 8));
            repeat (len) cycle(lvl);
            if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
